// File: rtl/apb_master_bridge_pkg.sv
// Shared types and constants for the APB master bridge.
// Holds the FSM state encoding, slave page map and store-width encodings.
// No logic; imported by the bridge top and the store aligner.
package apb_master_bridge_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETUP  = 2'd1,
      ST_ACCESS = 2'd2
   } state_e;

   // 4 KiB slave windows, matched on addr[31:12]
   localparam logic [19:0] SLV0_PAGE = 20'h10000;
   localparam logic [19:0] SLV1_PAGE = 20'h10001;
   localparam logic [19:0] SLV2_PAGE = 20'h10002;
   localparam logic [19:0] SLV3_PAGE = 20'h10003;

   // store widths as carried in the CPU func3 field
   localparam logic [2:0] F3_SB = 3'b000;
   localparam logic [2:0] F3_SH = 3'b001;
   localparam logic [2:0] F3_SW = 3'b010;

endpackage

// File: rtl/apb_store_aligner.sv
// Store lane aligner: builds APB byte strobes and lane-replicated write data.
// Latency: purely combinational, zero cycles.
// Backpressure: none; output follows the inputs every cycle.
module apb_store_aligner
   import apb_master_bridge_pkg::*;
(
   input  logic [2:0]  func3,
   input  logic [1:0]  addr_lo,
   input  logic [31:0] wdata,
   output logic [3:0]  pstrb,
   output logic [31:0] pwdata
);

   // pick strobe and replicated data from store width and byte offset
   always_comb begin
      pstrb  = 4'b0000;
      pwdata = wdata;
      case (func3)
         F3_SB: begin
            pstrb  = 4'b0001 << addr_lo;
            pwdata = {4{wdata[7:0]}};
         end
         F3_SH: begin
            pstrb  = 4'b0011 << {addr_lo[1], 1'b0};
            pwdata = {2{wdata[15:0]}};
         end
         F3_SW: begin
            pstrb  = 4'b1111;
         end
         default: begin
            pstrb  = 4'b0000;
         end
      endcase
   end

endmodule

// File: rtl/apb_master_bridge.sv
// CPU-to-APB master bridge with a four-slave address map and access timeout.
// Latency: 3 cycles minimum (accept, SETUP, ACCESS), plus slave wait states.
// Backpressure: new requests accepted only in IDLE; PREADY stretches ACCESS up to TIMEOUT_CYC cycles.
module apb_master_bridge
   import apb_master_bridge_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYC = 16
)
(
   input  logic        clk,
   input  logic        reset,
   input  logic        transfer,
   input  logic        write,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   input  logic [2:0]  func3,
   output logic [31:0] rdata,
   output logic        ready,
   output logic        err,
   output logic [31:0] PADDR,
   output logic        PWRITE,
   output logic        PENABLE,
   output logic [31:0] PWDATA,
   output logic [3:0]  PSTRB,
   output logic        PSEL0,
   output logic        PSEL1,
   output logic        PSEL2,
   output logic        PSEL3,
   input  logic [31:0] PRDATA0,
   input  logic [31:0] PRDATA1,
   input  logic [31:0] PRDATA2,
   input  logic [31:0] PRDATA3,
   input  logic        PREADY0,
   input  logic        PREADY1,
   input  logic        PREADY2,
   input  logic        PREADY3
);

   localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

   state_e            state_q, state_d;
   logic [31:0]       addr_q, addr_d;
   logic [31:0]       wdata_q, wdata_d;
   logic [2:0]        func3_q, func3_d;
   logic              write_q, write_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;

   logic              mapped;
   logic [1:0]        sel_idx;
   logic              pready_sel;
   logic [31:0]       prdata_sel;
   logic              timeout;
   logic              done;
   logic [3:0]        psel_vec;
   logic [3:0]        strb_al;
   logic [31:0]       pwdata_al;

   apb_store_aligner u_aligner (
      .func3   (func3_q),
      .addr_lo (addr_q[1:0]),
      .wdata   (wdata_q),
      .pstrb   (strb_al),
      .pwdata  (pwdata_al)
   );

   // decode the latched page to a slave index and mux that slave's response
   always_comb begin
      mapped  = 1'b1;
      sel_idx = 2'd0;
      case (addr_q[31:12])
         SLV0_PAGE: sel_idx = 2'd0;
         SLV1_PAGE: sel_idx = 2'd1;
         SLV2_PAGE: sel_idx = 2'd2;
         SLV3_PAGE: sel_idx = 2'd3;
         default:   mapped  = 1'b0;
      endcase
      case (sel_idx)
         2'd0:    begin pready_sel = PREADY0; prdata_sel = PRDATA0; end
         2'd1:    begin pready_sel = PREADY1; prdata_sel = PRDATA1; end
         2'd2:    begin pready_sel = PREADY2; prdata_sel = PRDATA2; end
         default: begin pready_sel = PREADY3; prdata_sel = PRDATA3; end
      endcase
   end

   // completion and error qualification; a synchronous reset suppresses the pulse
   always_comb begin
      timeout  = (state_q == ST_ACCESS) && (cnt_q == CNT_LAST);
      done     = (state_q == ST_ACCESS) && (!mapped || pready_sel || timeout);
      ready    = done && !reset;
      err      = ready && (!mapped || (timeout && !pready_sel));
      rdata    = (ready && !err) ? prdata_sel : 32'd0;
      psel_vec = ((state_q != ST_IDLE) && mapped) ? (4'b0001 << sel_idx) : 4'b0000;
      PSEL0    = psel_vec[0];
      PSEL1    = psel_vec[1];
      PSEL2    = psel_vec[2];
      PSEL3    = psel_vec[3];
      PENABLE  = (state_q == ST_ACCESS);
      PADDR    = addr_q;
      PWRITE   = write_q;
      PWDATA   = pwdata_al;
      PSTRB    = write_q ? strb_al : 4'b0000;
   end

   // next-state, request latch and ACCESS cycle counter
   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      func3_d = func3_q;
      write_d = write_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (transfer) begin
               addr_d  = addr;
               wdata_d = wdata;
               func3_d = func3;
               write_d = write;
               state_d = ST_SETUP;
            end
         end
         ST_SETUP: begin
            cnt_d   = '0;
            state_d = ST_ACCESS;
         end
         ST_ACCESS: begin
            cnt_d = cnt_q + 1'b1;
            if (done) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // state and latch registers with synchronous reset
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         addr_q  <= '0;
         wdata_q <= '0;
         func3_q <= '0;
         write_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         func3_q <= func3_d;
         write_q <= write_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule
